// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ALU ops, plus iterative MUL/DIVU/REMU when SEQ_ALU_MULDIV_EN is defined.
// Latency: 1 cycle for single-cycle ops, WIDTH cycles for MUL/DIVU/REMU (start edge to done_o edge).
// Backpressure: none; start_i is ignored while busy_o=1, and results are held until the next done_o.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [3:0]       ALU_Operation_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] ALU_Result_o,
    output logic             Zero_o
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SRL  = 4'b0011;
    localparam logic [3:0] OP_LUI  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_SLL  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1101;
    localparam logic [3:0] OP_DIVU = 4'b1110;
    localparam logic [3:0] OP_REMU = 4'b1111;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] single_d;
    logic [SHW-1:0]   shamt;

    assign shamt = B_i[SHW-1:0];

    // Multi-cycle opcodes fall into the default arm and yield 0 when the datapath is absent.
    always_comb begin
        single_d = '0;
        case (ALU_Operation_i)
            OP_ADD:  single_d = A_i + B_i;
            OP_SUB:  single_d = A_i - B_i;
            OP_SRL:  single_d = A_i >> shamt;
            OP_LUI:  single_d = {B_i[WIDTH-13:0], 12'b0};
            OP_OR:   single_d = A_i | B_i;
            OP_SLL:  single_d = A_i << shamt;
            default: single_d = '0;
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    localparam int CW = $clog2(WIDTH + 1);

    logic             busy_q;
    logic [CW-1:0]    cnt_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q;
    logic [WIDTH-1:0] a_d, b_d, acc_d, final_d;
    logic [WIDTH:0]   rem_sh, diff;
    logic             is_multi;

    assign is_multi = (ALU_Operation_i == OP_MUL) || (ALU_Operation_i == OP_DIVU) ||
                      (ALU_Operation_i == OP_REMU);

    // MUL: acc accumulates shifted multiplicand. DIV: a_q shifts dividend out and quotient in.
    always_comb begin
        rem_sh  = {acc_q, a_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, b_q};
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        final_d = '0;
        if (op_q == OP_MUL) begin
            acc_d   = b_q[0] ? (acc_q + a_q) : acc_q;
            a_d     = a_q << 1;
            b_d     = b_q >> 1;
            final_d = acc_d;
        end else begin
            if (!diff[WIDTH]) begin
                acc_d = diff[WIDTH-1:0];
                a_d   = {a_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = rem_sh[WIDTH-1:0];
                a_d   = {a_q[WIDTH-2:0], 1'b0};
            end
            final_d = (op_q == OP_DIVU) ? a_d : acc_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (is_multi) begin
                            op_q    <= ALU_Operation_i;
                            a_q     <= A_i;
                            b_q     <= B_i;
                            acc_q   <= '0;
                            cnt_q   <= CW'(WIDTH);
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end else begin
                            result_q <= single_d;
                            done_q   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_q <= final_d;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q  <= 1'b0;
            state_q <= IDLE;
            if (start_i) begin
                result_q <= single_d;
                done_q   <= 1'b1;
            end
        end
    end

    assign busy_o = 1'b0;
`endif

    assign done_o       = done_q;
    assign ALU_Result_o = result_q;
    assign Zero_o       = (result_q == '0);

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32); multi-cycle checks are selected by SEQ_ALU_MULDIV_EN.
module tb_seq_alu;
    localparam int W = 32;

    typedef struct {
        string       nm;
        logic [3:0]  op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start_i = 1'b0;
    logic [3:0]   op = 4'h0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy_o, done_o, zero_o;
    logic [W-1:0] res_o;

    int   total = 0;
    int   bad = 0;
    logic busy_seen = 1'b0;
    vec_t vq[$];

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .ALU_Operation_i(op),
        .A_i(a), .B_i(b), .busy_o(busy_o), .done_o(done_o),
        .ALU_Result_o(res_o), .Zero_o(zero_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busy_o === 1'b1) busy_seen <= 1'b1;

    initial begin
        #400000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Leaves start_i high so consecutive calls are issued back-to-back.
    task automatic apply(input string nm, input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] exp);
        @(negedge clk);
        op = o; a = x; b = y; start_i = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_done"}, W'(done_o), W'(1));
        chk({nm, "_res"}, res_o, exp);
        chk({nm, "_zero"}, W'(zero_o), W'(exp == '0));
        chk({nm, "_busy"}, W'(busy_o), W'(0));
    endtask

    task automatic run_multi(input string nm, input logic [3:0] o, input logic [W-1:0] x,
                             input logic [W-1:0] y, input logic [W-1:0] exp);
        int   n;
        logic busy_ok;
        @(negedge clk);
        op = o; a = x; b = y; start_i = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_busy_start"}, W'(busy_o), W'(1));
        chk({nm, "_nodone_start"}, W'(done_o), W'(0));
        @(negedge clk);
        start_i = 1'b0; a = '1; b = '1; op = 4'h0;
        n = 0; busy_ok = 1'b1;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            if (done_o) break;
            if (!busy_o) busy_ok = 1'b0;
        end
        chk({nm, "_latency"}, W'(n), W'(W));
        chk({nm, "_busy_held"}, W'(busy_ok), W'(1));
        chk({nm, "_res"}, res_o, exp);
        chk({nm, "_zero"}, W'(zero_o), W'(exp == '0));
        chk({nm, "_busy_end"}, W'(busy_o), W'(0));
        @(posedge clk); #1;
        chk({nm, "_pulse"}, W'(done_o), W'(0));
        chk({nm, "_hold"}, res_o, exp);
    endtask

    initial begin
        vq.push_back('{"add",    4'b0000, 32'd5,        32'd3,        32'd8});
        vq.push_back('{"sub0",   4'b0001, 32'd9,        32'd9,        32'd0});
        vq.push_back('{"sub_neg",4'b0001, 32'd3,        32'd5,        32'hFFFF_FFFE});
        vq.push_back('{"add_ovf",4'b0000, 32'hFFFF_FFFF, 32'd1,       32'd0});
        vq.push_back('{"srl",    4'b0011, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000});
        vq.push_back('{"lui",    4'b1000, 32'd0,        32'h0001_2345, 32'h1234_5000});
        vq.push_back('{"lui_hi", 4'b1000, 32'd7,        32'hABC1_2345, 32'h1234_5000});
        vq.push_back('{"or",     4'b1001, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF});
        vq.push_back('{"sll31",  4'b1100, 32'd1,        32'd31,       32'h8000_0000});
        vq.push_back('{"sll32",  4'b1100, 32'd1,        32'd32,       32'd1});
        vq.push_back('{"illegal",4'b0010, 32'd5,        32'd3,        32'd0});
`ifndef SEQ_ALU_MULDIV_EN
        vq.push_back('{"mul_off", 4'b1101, 32'd7,   32'd6, 32'd0});
        vq.push_back('{"divu_off",4'b1110, 32'd100, 32'd7, 32'd0});
        vq.push_back('{"remu_off",4'b1111, 32'd100, 32'd7, 32'd0});
`endif

        #1;
        chk("rst_busy", W'(busy_o), W'(0));
        chk("rst_done", W'(done_o), W'(0));
        chk("rst_res", res_o, '0);
        chk("rst_zero", W'(zero_o), W'(1));
        repeat (2) @(negedge clk);
        reset = 1'b1;

        foreach (vq[i]) apply(vq[i].nm, vq[i].op, vq[i].a, vq[i].b, vq[i].res);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        chk("idle_nodone", W'(done_o), W'(0));
        chk("idle_hold", res_o, vq[vq.size()-1].res);

`ifdef SEQ_ALU_MULDIV_EN
        begin
            int dn;
            int first;
            run_multi("mul", 4'b1101, 32'd7, 32'd6, 32'd42);
            apply("lui_after", 4'b1000, 32'd0, 32'h0001_2345, 32'h1234_5000);
            run_multi("mul_big", 4'b1101, 32'h0001_0001, 32'hFFFF_0000, 32'hFFFF_0000);
            run_multi("divu", 4'b1110, 32'd100, 32'd7, 32'd14);
            run_multi("remu", 4'b1111, 32'd100, 32'd7, 32'd2);
            run_multi("divu0", 4'b1110, 32'd5, 32'd0, 32'hFFFF_FFFF);
            run_multi("remu0", 4'b1111, 32'd5, 32'd0, 32'd5);

            @(negedge clk);
            op = 4'b1101; a = 32'd3; b = 32'd4; start_i = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
            dn = 0; first = 0;
            for (int c = 1; c <= 40; c++) begin
                @(posedge clk); #1;
                if (done_o) begin
                    dn++;
                    if (first == 0) first = c;
                end
                if (c == 9) begin
                    op = 4'b0000; a = 32'd1; b = 32'd1; start_i = 1'b1;
                end else begin
                    start_i = 1'b0; a = 32'd99;
                end
            end
            chk("busy_start_pulses", W'(dn), W'(1));
            chk("busy_start_cycle", W'(first), W'(W));
            chk("busy_start_res", res_o, 32'd12);

            @(negedge clk);
            op = 4'b1110; a = 32'd100; b = 32'd7; start_i = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
            repeat (14) @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            #1;
            chk("mid_rst_busy", W'(busy_o), W'(0));
            chk("mid_rst_res", res_o, '0);
            chk("mid_rst_zero", W'(zero_o), W'(1));
            dn = 0;
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                if (done_o) dn++;
            end
            @(negedge clk);
            reset = 1'b1;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk); #1;
                if (done_o) dn++;
            end
            chk("mid_rst_nodone", W'(dn), W'(0));
            apply("add_after_rst", 4'b0000, 32'd1, 32'd1, 32'd2);
            @(negedge clk);
            start_i = 1'b0;
        end
`else
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst2_res", res_o, '0);
        chk("rst2_zero", W'(zero_o), W'(1));
        @(negedge clk);
        reset = 1'b1;
        apply("mul_off_again", 4'b1101, 32'd7, 32'd6, 32'd0);
        apply("add_after_rst", 4'b0000, 32'd1, 32'd1, 32'd2);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        chk("busy_never", W'(busy_seen), W'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits; legal range 16..64.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  active-low reset.
REQ-004 SHALL have port start_i  input  1  operation request, sampled on rising clk edge.
REQ-005 SHALL have port ALU_Operation_i  input  4  opcode.
REQ-006 SHALL have port A_i  input  WIDTH  operand A.
REQ-007 SHALL have port B_i  input  WIDTH  operand B.
REQ-008 SHALL have port busy_o  output  1  multi-cycle operation in progress.
REQ-009 SHALL have port done_o  output  1  one-cycle pulse: result valid.
REQ-010 SHALL have port ALU_Result_o  output  WIDTH  registered result.
REQ-011 SHALL have port Zero_o  output  1  high when ALU_Result_o is zero.
REQ-012 SHALL use one clock, clk; reset SHALL be asynchronous and active-low.

Function
REQ-013 SHALL decode single-cycle ops: ADD 0000 = A+B; SUB 0001 = A-B; SRL 0011 = A logical-right-shifted by B; LUI 1000 = {B[WIDTH-13:0],12'b0}; OR 1001 = A|B; SLL 1100 = A<<B.
REQ-014 SHALL use only B[$clog2(WIDTH)-1:0] as the shift amount; upper B bits are ignored.
REQ-015 SHALL decode multi-cycle ops: MUL 1101 = low WIDTH bits of unsigned A*B; DIVU 1110 = unsigned A/B; REMU 1111 = unsigned A%B.
REQ-016 SHALL treat every other opcode as single-cycle with result 0.
REQ-017 SHALL implement an FSM with states IDLE and RUN.
REQ-018 In IDLE, start_i=1 with a single-cycle op SHALL register the result and Zero_o and pulse done_o in the next cycle; the FSM SHALL stay in IDLE, giving throughput of one op per cycle.
REQ-019 In IDLE, start_i=1 with a multi-cycle op SHALL latch the operands, load the iteration counter with WIDTH, and enter RUN with busy_o=1.
REQ-020 In RUN, SHALL perform one iteration per cycle: shift-add for MUL, restoring shift-subtract for DIVU/REMU.
REQ-021 SHALL, on the WIDTH-th RUN edge after the start edge, load ALU_Result_o and Zero_o, pulse done_o for one cycle, clear busy_o, and return to IDLE; latency is WIDTH cycles.
REQ-022 SHALL ignore start_i while busy_o=1, leaving the operation in progress undisturbed.
REQ-023 SHALL accept start_i in the cycle done_o is high, since the FSM is then in IDLE.
REQ-024 DIVU with B=0 SHALL return all ones; REMU with B=0 SHALL return A; both take the full WIDTH-cycle latency.
REQ-025 SHALL hold ALU_Result_o and Zero_o stable between done_o pulses.
REQ-026 SHALL compute Zero_o from the registered result, so Zero_o always agrees with ALU_Result_o.
REQ-027 SHALL ignore operand and opcode inputs after the start edge; a multi-cycle op uses only the latched copies.

Reset
REQ-028 SHALL, while reset=0, force state IDLE, busy_o=0, done_o=0, ALU_Result_o=0, Zero_o=1, and clear the counter and working registers.
REQ-029 Reset asserted during RUN SHALL abort the operation with no done_o pulse; the first start after release SHALL operate normally.

Configuration
REQ-030 SHALL use macro SEQ_ALU_MULDIV_EN: when defined, MUL/DIVU/REMU behave as in REQ-015..REQ-024.
REQ-031 SHALL, without SEQ_ALU_MULDIV_EN, omit the multiply/divide datapath and iteration counter; opcodes 1101/1110/1111 are single-cycle with result 0, and busy_o is tied 0.

Verification (WIDTH=32, macro defined unless stated)
REQ-032 SHALL test ADD: A=5, B=3, start -> next cycle done_o=1, ALU_Result_o=8, Zero_o=0; then SUB A=B=9 back-to-back -> next cycle result 0, Zero_o=1.
REQ-033 SHALL test MUL: A=7, B=6 -> busy_o high 32 cycles, done_o on 32nd edge, result 42; LUI B=0x12345 -> 0x12345000 in 1 cycle.
REQ-034 SHALL test division: DIVU 100/7 -> 14, REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5.
REQ-035 SHALL test start while busy: MUL 3*4 started, then ADD pulsed at cycle 10 -> ignored; single done_o with result 12.
REQ-036 SHALL test reset mid-run: DIVU started, reset low at cycle 15 -> busy_o=0, result 0, Zero_o=1, no done_o; next ADD 1+1 -> 2.
REQ-037 SHALL test with macro undefined: MUL 7*6 -> done_o after 1 cycle, result 0, busy_o never high.
